unary_operand_driver: RTL
=========================

// Module: unary_operand_driver
// PURPOSE
//   Upstream stage of the 12-bit unary adder. Accepts two binary operands over a
//   valid/ready handshake and converts each into a return-to-zero unary pulse train.
//   It drives the adder's A, B, en and read_or_write inputs, then holds the adder in
//   read mode for a fixed window. Each operand value N becomes exactly N one-cycle
//   pulses.
// PARAMETERS
//   WIDTH        12  operand width; max pulses per operand = 2**WIDTH-1
//   GAP           1  low cycles after each pulse (>=1, so pulses never merge)
//   READ_CYCLES  20  cycles read_or_write is held high after streaming (>=1)
// PORTS
//   clk        in   1      system clock, all state updates on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   clear      in   1      synchronous abort, returns block to IDLE
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      block can accept operands (combinational: state==IDLE)
//   in_a       in   WIDTH  operand A, binary
//   in_b       in   WIDTH  operand B, binary
//   a_out      out  1      unary stream to adder A
//   b_out      out  1      unary stream to adder B
//   en_out     out  1      adder enable
//   rw_out     out  1      adder read_or_write: 0 = accumulate, 1 = read
//   done       out  1      one-cycle pulse when the read window ends
// BEHAVIOUR
//   - Reset (rst_n=0): state=IDLE; a_out, b_out, en_out, rw_out, done = 0;
//     internal counters = 0. in_ready reads 1 once in IDLE.
//   - FSM states and transitions:
//       IDLE   -> STREAM on in_valid & in_ready.
//       STREAM -> READ when both counters are 0 at a pulse slot.
//       READ   -> DONE after READ_CYCLES cycles.
//       DONE   -> IDLE after one cycle.
//   - Accept edge t0: latch cnt_a=in_a, cnt_b=in_b, phase=0; en_out goes 1 at t0.
//   - STREAM slot model, registered outputs:
//       - A slot is 1 pulse cycle followed by GAP low cycles.
//       - At slot edge t0+1+(GAP+1)*i: a_out=(cnt_a!=0), b_out=(cnt_b!=0).
//         Each nonzero counter decrements by 1.
//       - On the following GAP edges, a_out=b_out=0.
//   - The shorter stream stays low while the longer one finishes. A and B pulses
//     are coincident slot-for-slot.
//   - READ entry edge: tr = t0+1+(GAP+1)*max(A,B). At tr, a_out=b_out=0 and rw_out=1.
//     en_out stays 1.
//   - Zero operands: A=B=0 gives tr=t0+1 with no pulses.
//   - DONE edge td=tr+READ_CYCLES: done=1, rw_out=0, en_out=0.
//     At td+1: done=0, state=IDLE, in_ready=1.
//   - in_valid while busy is ignored; in_a and in_b are only sampled on the accept edge.
//   - clear (any state) has priority over all transitions. Next edge: IDLE, all
//     outputs 0, counters 0. done is NOT pulsed.
//   - clear in the same cycle as in_valid in IDLE: the operands are not accepted.
//   - Async reset mid-stream: outputs drop immediately and no partial state survives.
//   - Counters are WIDTH bits, decrement only when nonzero, and never wrap.
//   - Sum overflow (A+B >= 2**WIDTH) is the adder's concern (its carry flag). This
//     block passes both streams unaltered.
//   - Pulse count invariant: the number of high cycles on a_out equals the accepted
//     in_a exactly; likewise for b_out and in_b.
// TESTING
//   1. Reset then A=3, B=5, defaults:
//      - a_out highs at t0+1, +3, +5; b_out highs at t0+1 .. +9 step 2.
//      - rw_out rises at t0+11; done at t0+31; in_ready=1 at t0+32.
//   2. A=0, B=0: no pulses; rw_out=1 at t0+1; done at t0+21.
//   3. A=4095, B=4095, GAP=1: 4095 pulses on each output; rw_out at t0+8191.
//      The downstream adder model shows C=1 and count=4094.
//   4. A=2, B=0: b_out never high; a_out highs at t0+1, t0+3; rw_out at t0+5.
//   5. clear asserted mid-STREAM after 2 pulses of A=6:
//      - Next edge: all outputs 0, in_ready=1, no done pulse.
//      - A new pair A=1, B=1 then streams correctly.
//   6. Back-to-back transfers with in_valid held high:
//      - Second pair accepted only at td+1.
//      - Operand changes while busy do not alter the pulse counts.
//      - Async reset pulsed mid-READ forces all outputs to 0 immediately.

Source files
------------

// File: rtl/unary_operand_driver.sv
// Binary-to-unary front end for the unary adder: streams two operands
// as return-to-zero pulse trains, then holds the adder in read mode.
module unary_operand_driver #(
  parameter int WIDTH       = 12,
  parameter int GAP         = 1,
  parameter int READ_CYCLES = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             a_out,
  output logic             b_out,
  output logic             en_out,
  output logic             rw_out,
  output logic             done
);

  localparam int PW = $clog2(GAP + 1);
  localparam int RW = $clog2(READ_CYCLES + 1);
  localparam logic [PW-1:0] GAP_V = PW'(GAP);
  localparam logic [RW-1:0] RLAST = RW'(READ_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    READ,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [WIDTH-1:0] cnt_a_q, cnt_a_d;
  logic [WIDTH-1:0] cnt_b_q, cnt_b_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [RW-1:0] rd_q, rd_d;
  logic a_q, a_d;
  logic b_q, b_d;
  logic en_q, en_d;
  logic rw_q, rw_d;
  logic done_q, done_d;
  logic a_nz, b_nz;

  assign a_nz = (cnt_a_q != '0);
  assign b_nz = (cnt_b_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      phase_q <= '0;
      rd_q    <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      en_q    <= 1'b0;
      rw_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      phase_q <= phase_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      en_q    <= en_d;
      rw_q    <= rw_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    phase_d = phase_q;
    rd_d    = rd_q;
    a_d     = 1'b0;
    b_d     = 1'b0;
    en_d    = en_q;
    rw_d    = rw_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = STREAM;
          cnt_a_d = in_a;
          cnt_b_d = in_b;
          phase_d = '0;
          en_d    = 1'b1;
        end
      end
      STREAM: begin
        if (phase_q != '0) begin
          phase_d = phase_q - 1'b1;
        end else if (!a_nz && !b_nz) begin
          state_d = READ;
          rw_d    = 1'b1;
          rd_d    = '0;
        end else begin
          // pulse slot: emit and consume one unit per live operand
          a_d     = a_nz;
          b_d     = b_nz;
          cnt_a_d = cnt_a_q - WIDTH'(a_nz);
          cnt_b_d = cnt_b_q - WIDTH'(b_nz);
          phase_d = GAP_V;
        end
      end
      READ: begin
        if (rd_q == RLAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          rw_d    = 1'b0;
          en_d    = 1'b0;
          rd_d    = '0;
        end else begin
          rd_d = rd_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (clear) begin
      state_d = IDLE;
      cnt_a_d = '0;
      cnt_b_d = '0;
      phase_d = '0;
      rd_d    = '0;
      a_d     = 1'b0;
      b_d     = 1'b0;
      en_d    = 1'b0;
      rw_d    = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign a_out    = a_q;
  assign b_out    = b_q;
  assign en_out   = en_q;
  assign rw_out   = rw_q;
  assign done     = done_q;

endmodule
